// File: rtl/run_control_pkg.sv
// run_control_pkg: shared state and halt-reason types for the run/halt controller
package run_control_pkg;
    localparam int REASON_W = 2;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALT} state_t;
    typedef enum logic [REASON_W-1:0] {
        R_NONE    = 2'd0,
        R_INSTR   = 2'd1,
        R_TIMEOUT = 2'd2
    } halt_reason_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge CLOCK) begin
        if (RESET || clr) count <= '0;
        else if (inc && !(&count)) count <= count + 1'b1;
    end
endmodule

// File: rtl/run_control.sv
// run_control: run/step/halt clock-enable controller with saturating cycle count.
// Define RUN_CONTROL_WATCHDOG_EN to halt with TIMEOUT once CYCLE_LIMIT cycles have run.
module run_control
    import run_control_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic                   STOP,
    input  logic                   STEP,
    input  logic                   CLEAR,
    input  logic                   HALT_REQ,
    input  logic [COUNT_WIDTH-1:0] CYCLE_LIMIT,
    output logic                   CPU_EN,
    output logic                   RUNNING,
    output logic                   HALTED,
    output logic                   DONE,
    output logic [REASON_W-1:0]    HALT_REASON,
    output logic [COUNT_WIDTH-1:0] CYCLE_COUNT
);
    state_t       state, next;
    halt_reason_t reason;
    logic         limit_hit;
    logic         entering_halt;
`ifdef RUN_CONTROL_WATCHDOG_EN
    // Fires on the edge that counts the CYCLE_LIMIT-th cycle; a saturated count wraps to 0 here and never matches.
    assign limit_hit = state == S_RUN && CYCLE_LIMIT != '0 &&
                       COUNT_WIDTH'(CYCLE_COUNT + 1'b1) == CYCLE_LIMIT;
`else
    logic unused_limit;
    assign unused_limit = ^CYCLE_LIMIT;
    assign limit_hit    = 1'b0;
`endif
    always_comb begin
        next = state;
        case (state)
            S_IDLE:  next = START ? S_RUN : STEP ? S_STEP : S_IDLE;
            S_RUN:   next = (HALT_REQ || limit_hit) ? S_HALT : STOP ? S_IDLE : S_RUN;
            S_STEP:  next = HALT_REQ ? S_HALT : S_IDLE;
            default: next = S_HALT;
        endcase
        if (CLEAR) next = S_IDLE;
    end
    assign entering_halt = next == S_HALT && state != S_HALT;
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state   <= S_IDLE;
            reason  <= R_NONE;
            CPU_EN  <= 1'b0;
            RUNNING <= 1'b0;
            HALTED  <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state   <= next;
            CPU_EN  <= next == S_RUN || next == S_STEP;
            RUNNING <= next == S_RUN;
            HALTED  <= next == S_HALT;
            DONE    <= entering_halt;
            if (CLEAR) reason <= R_NONE;
            else if (entering_halt) reason <= HALT_REQ ? R_INSTR : R_TIMEOUT;
        end
    end
    assign HALT_REASON = reason;
    sat_counter #(.WIDTH(COUNT_WIDTH)) u_cycles (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .clr  (CLEAR),
        .inc  (CPU_EN),
        .count(CYCLE_COUNT)
    );
endmodule

// File: tb/tb_run_control.sv
// tb_run_control: directed checks of run/step/halt sequencing, counting and saturation
module tb_run_control;
    logic        CLOCK = 1'b0;
    logic        RESET, START, STOP, STEP, CLEAR, HALT_REQ;
    logic [31:0] CYCLE_LIMIT;
    logic [3:0]  lim4;
    logic        CPU_EN, RUNNING, HALTED, DONE;
    logic [1:0]  HALT_REASON;
    logic [31:0] CYCLE_COUNT;
    logic        en4, run4, halt4, done4;
    logic [1:0]  reason4;
    logic [3:0]  count4;
    int          checks = 0;
    int          errors = 0;
    int          en_cycles;

    always #5 CLOCK = ~CLOCK;

    run_control #(.COUNT_WIDTH(32)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .STOP(STOP), .STEP(STEP),
        .CLEAR(CLEAR), .HALT_REQ(HALT_REQ), .CYCLE_LIMIT(CYCLE_LIMIT),
        .CPU_EN(CPU_EN), .RUNNING(RUNNING), .HALTED(HALTED), .DONE(DONE),
        .HALT_REASON(HALT_REASON), .CYCLE_COUNT(CYCLE_COUNT)
    );

    run_control #(.COUNT_WIDTH(4)) dut4 (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .STOP(STOP), .STEP(STEP),
        .CLEAR(CLEAR), .HALT_REQ(HALT_REQ), .CYCLE_LIMIT(lim4),
        .CPU_EN(en4), .RUNNING(run4), .HALTED(halt4), .DONE(done4),
        .HALT_REASON(reason4), .CYCLE_COUNT(count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic pulse_clear();
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
    endtask

    initial begin
        {START, STOP, STEP, CLEAR, HALT_REQ} = '0;
        CYCLE_LIMIT = '0;
        lim4 = '0;
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        check("rst_en", CPU_EN, 0);
        check("rst_running", RUNNING, 0);
        check("rst_halted", HALTED, 0);
        check("rst_done", DONE, 0);
        check("rst_reason", HALT_REASON, 0);
        check("rst_count", CYCLE_COUNT, 0);

        // start, halt instruction in the 5th enabled cycle
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_latency_en", CPU_EN, 1);
        check("start_count0", CYCLE_COUNT, 0);
        en_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            en_cycles += int'(CPU_EN);
            tick();
        end
        en_cycles += int'(CPU_EN);
        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        check("instr_en_cycles", en_cycles, 5);
        check("instr_count", CYCLE_COUNT, 5);
        check("instr_halted", HALTED, 1);
        check("instr_en_low", CPU_EN, 0);
        check("instr_reason", HALT_REASON, 1);
        check("instr_done", DONE, 1);
        tick();
        check("done_one_cycle", DONE, 0);
        check("halt_sticky", HALTED, 1);
        pulse_clear();
        check("clr_count", CYCLE_COUNT, 0);
        check("clr_reason", HALT_REASON, 0);
        check("clr_idle", HALTED | RUNNING | CPU_EN, 0);

        // three single-cycle step pulses, 4 cycles apart
        en_cycles = 0;
        for (int p = 0; p < 3; p++) begin
            STEP = 1'b1;
            tick();
            STEP = 1'b0;
            check("step_en_high", CPU_EN, 1);
            for (int i = 0; i < 3; i++) begin
                en_cycles += int'(CPU_EN);
                tick();
                check("step_en_low", CPU_EN, 0);
            end
        end
        check("step_pulses", en_cycles, 3);
        check("step_count", CYCLE_COUNT, 3);
        check("step_idle", RUNNING | HALTED, 0);
        pulse_clear();

        // run, stop (with start held too: stop wins), restart, halt at 9
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("ss_count6", CYCLE_COUNT, 6);
        START = 1'b1;
        STOP = 1'b1;
        tick();
        {START, STOP} = '0;
        check("stop_wins_idle", RUNNING, 0);
        check("stop_en_low", CPU_EN, 0);
        check("stop_keeps_count", CYCLE_COUNT, 7);
        tick();
        check("idle_count_hold", CYCLE_COUNT, 7);
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        check("restart_count8", CYCLE_COUNT, 8);
        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        check("rehalt_count", CYCLE_COUNT, 9);
        check("rehalt_reason", HALT_REASON, 1);
        START = 1'b1;
        STEP = 1'b1;
        tick();
        {START, STEP} = '0;
        check("halt_ignores_start", HALTED, 1);
        check("halt_ignores_en", CPU_EN, 0);
        check("halt_count_hold", CYCLE_COUNT, 9);
        pulse_clear();
        check("clr2_idle", HALTED, 0);
        check("clr2_count", CYCLE_COUNT, 0);
        check("clr2_reason", HALT_REASON, 0);

        // start and stop together in idle: start wins
        START = 1'b1;
        STOP = 1'b1;
        tick();
        START = 1'b0;
        check("start_wins_idle", RUNNING, 1);
        tick();
        STOP = 1'b0;
        check("stop_after_one", CYCLE_COUNT, 1);
        // halt request while disabled is ignored
        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        check("halt_req_ignored", HALTED, 0);
        pulse_clear();

        // cycle budget of 10
        CYCLE_LIMIT = 32'd10;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 10; i++) tick();
`ifdef RUN_CONTROL_WATCHDOG_EN
        check("wd_halted", HALTED, 1);
        check("wd_count", CYCLE_COUNT, 10);
        check("wd_reason", HALT_REASON, 2);
        check("wd_done", DONE, 1);
`else
        for (int i = 0; i < 10; i++) tick();
        check("nowd_running", RUNNING, 1);
        check("nowd_count", CYCLE_COUNT, 20);
        check("nowd_reason", HALT_REASON, 0);
`endif
        pulse_clear();
        CYCLE_LIMIT = '0;

        // 4-bit counter saturates; reset mid-run
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("free_count", CYCLE_COUNT, 20);
        check("sat_count4", count4, 15);
        check("sat_running4", run4, 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("mid_rst_en", CPU_EN, 0);
        check("mid_rst_running", RUNNING, 0);
        check("mid_rst_count", CYCLE_COUNT, 0);
        check("mid_rst_count4", count4, 0);
        check("mid_rst_flags", {HALTED, DONE, HALT_REASON}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/run_control.md
# run_control

Run/halt controller downstream of the `clock` generator. It consumes `CLOCK` and produces a clock-enable (`CPU_EN`) that gates every state element of the single-cycle CPU. The CPU therefore runs freely, single-steps, or halts on a halt instruction or a cycle budget. It also keeps a saturating count of executed cycles for the testbench and the debug display.

## Interface
- `COUNT_WIDTH`, 32: width of the executed-cycle counter and of the cycle limit.
- `CLOCK` input 1: the only clock. All logic is sampled on the rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `START` input 1: level. Requests free-running execution.
- `STOP` input 1: level. Pauses free-running execution and returns to idle.
- `STEP` input 1: level. Requests exactly one enabled cycle.
- `CLEAR` input 1: level. Leaves `HALT`, zeroes the counter and clears the reason.
- `HALT_REQ` input 1: from CPU decode. Asserted while a halt instruction executes.
- `CYCLE_LIMIT` input COUNT_WIDTH: cycle budget. 0 means unlimited.
- `CPU_EN` output 1: CPU clock-enable.
- `RUNNING` output 1: high in `RUN`.
- `HALTED` output 1: high in `HALT`.
- `DONE` output 1: one-cycle pulse on entry to `HALT`.
- `HALT_REASON` output 2: encoded halt cause.
- `CYCLE_COUNT` output COUNT_WIDTH: number of enabled cycles executed.

## Operation
- There is one clock. Reset is synchronous and active-high.
- States: `IDLE`, `RUN`, `STEP`, `HALT`. All outputs are Moore, decoded from registered state and registers.
- `CPU_EN` = (state == `RUN`) or (state == `STEP`).
- Input priority at each edge: `CLEAR` > `HALT_REQ` > limit hit > `STOP` > `START` > `STEP`.
- `IDLE`:
  - `START` -> `RUN`.
  - Otherwise `STEP` -> `STEP`.
  - Otherwise stay.
- `RUN`:
  - `HALT_REQ` -> `HALT` with reason INSTR.
  - Limit hit -> `HALT` with reason TIMEOUT.
  - `STOP` -> `IDLE`.
  - Otherwise stay.
- `STEP`:
  - `HALT_REQ` -> `HALT` with reason INSTR.
  - Otherwise -> `IDLE`, always after exactly one enabled cycle.
  - A `STEP` held high re-steps every second cycle (`IDLE`/`STEP` alternation). This is intended behaviour.
- `HALT`: sticky. `START`, `STOP` and `STEP` are ignored. `CLEAR` -> `IDLE`.
- `CLEAR` is honoured in every state. It forces `IDLE`, sets `CYCLE_COUNT` = 0 and sets `HALT_REASON` = NONE.
- `HALT_REQ` is ignored when `CPU_EN` is low.
- `HALT_REASON` encoding: NONE = 0, INSTR = 1, TIMEOUT = 2. It is loaded only on entry to `HALT` and holds until `CLEAR` or `RESET`.
- `CYCLE_COUNT` increments at every edge where `CPU_EN` is high. This includes the cycle in which `HALT_REQ` is seen.
  - It saturates at all-ones and never wraps.
  - `STOP` does not clear it.
- `DONE` is high for exactly the first cycle in `HALT`.

## Timing
- Reset values: state `IDLE`, `CPU_EN` 0, `RUNNING` 0, `HALTED` 0, `DONE` 0, `HALT_REASON` NONE, `CYCLE_COUNT` 0.
- `RESET` mid-run takes effect at the next edge. `CPU_EN` is low in the following cycle.
- Start latency: `START` sampled at edge k. `CPU_EN` is high from edge k through the cycle after edge k.
- Halt latency: `HALT_REQ` is high in cycle n (with `CPU_EN` high). At edge n+1, `CYCLE_COUNT` counts cycle n, the state becomes `HALT`, and `CPU_EN` is low.
- Simultaneous `START` and `STOP` in `IDLE`: `START` wins and the block enters `RUN`.
- Simultaneous `STOP` and `START` in `RUN`: `STOP` wins and the block enters `IDLE`.

## Configuration
- Macro: `RUN_CONTROL_WATCHDOG_EN`.
- Defined:
  - The limit is hit at an edge in `RUN` when `CYCLE_LIMIT` != 0 and `CYCLE_COUNT` + 1 == `CYCLE_LIMIT`.
  - On a hit the block enters `HALT` with reason TIMEOUT, after exactly `CYCLE_LIMIT` cycles are counted.
  - A `CYCLE_LIMIT` already ≤ `CYCLE_COUNT` never fires.
- Undefined: `CYCLE_LIMIT` is present but ignored. TIMEOUT is never produced.

## Structure
- `run_control_pkg` holds:
  - the `state_t` enum;
  - the `halt_reason_t` enum (NONE/INSTR/TIMEOUT);
  - the 2-bit reason width constant.
- Sub-module `sat_counter` (parameter `WIDTH`; inputs `CLOCK`, `RESET`, `clr`, `inc`; output `count`) implements `CYCLE_COUNT`. It also serves the later performance counters.

## Test plan
- Reset, then `START` for 1 cycle, `HALT_REQ` in the 5th enabled cycle -> `CPU_EN` high 5 cycles, `CYCLE_COUNT` = 5, `HALT_REASON` = 1, `DONE` high 1 cycle.
- Three `STEP` pulses of 1 cycle each, spaced 4 cycles apart -> exactly 3 single-cycle `CPU_EN` pulses, `CYCLE_COUNT` = 3, state `IDLE`.
- Watchdog build, `CYCLE_LIMIT` = 10, `START` -> halt after 10 enabled cycles, `HALT_REASON` = 2. In the non-watchdog build it is still running at cycle 20.
- `RUN`, `STOP` at count 7, `START` again, `HALT_REQ` at count 9 -> `CYCLE_COUNT` = 9. In `HALT`, `START` is ignored. `CLEAR` -> `IDLE`, count 0, reason 0.
- `COUNT_WIDTH` = 4, free run for 20 cycles -> `CYCLE_COUNT` saturates at 15. `RESET` asserted mid-run -> all outputs return to reset values one edge later.
